// File: rtl/chess_pkg.sv
// Shared chess encodings: piece/color codes, commit FSM states and square-index helpers.
// A square index is {column, row}; row 0 is the black home row.
package chess_pkg;

   localparam logic       WHITE  = 1'b0;
   localparam logic       BLACK  = 1'b1;

   localparam logic [2:0] EMPTY  = 3'b000;
   localparam logic [2:0] KING   = 3'b001;
   localparam logic [2:0] QUEEN  = 3'b010;
   localparam logic [2:0] BISHOP = 3'b011;
   localparam logic [2:0] KNIGHT = 3'b100;
   localparam logic [2:0] ROOK   = 3'b101;
   localparam logic [2:0] PAWN   = 3'b110;

   localparam logic [2:0] GAME_INIT = 3'b000;

   typedef enum logic [2:0] {IDLE, WDST, WSRC, RDST, RSRC, DONE} commit_state_e;

   function automatic logic [2:0] sq_col(input logic [5:0] sq);
      return sq[5:3];
   endfunction

   function automatic logic [2:0] sq_row(input logic [5:0] sq);
      return sq[2:0];
   endfunction

   function automatic logic [5:0] make_sq(input logic [2:0] col, input logic [2:0] row);
      return {col, row};
   endfunction

endpackage

// File: rtl/move_classify.sv
// Combinational move classification: pawn promotion, castle detection and the
// rook relocation squares that a castle implies.
module move_classify
   import chess_pkg::*;
#(
   parameter logic [2:0] PROMOTE_TYPE = QUEEN
) (
   input  logic [5:0] from_sq,
   input  logic [5:0] to_sq,
   input  logic [3:0] src_piece,
   output logic [3:0] new_piece,
   output logic       is_castle,
   output logic [3:0] rook_piece,
   output logic [5:0] rook_dst,
   output logic [5:0] rook_src
);

   logic       color;
   logic [2:0] ptype;
   logic [2:0] row;

   always_comb begin
      color      = src_piece[3];
      ptype      = src_piece[2:0];
      row        = sq_row(from_sq);
      new_piece  = src_piece;
      rook_piece = {color, ROOK};

      // White pawns travel toward row 0, black pawns toward row 7.
      if (ptype == PAWN &&
          ((color == WHITE && sq_row(to_sq) == 3'd0) ||
           (color == BLACK && sq_row(to_sq) == 3'd7)))
         new_piece = {color, PROMOTE_TYPE};

      is_castle = (ptype == KING) && (sq_col(from_sq) == 3'd4) &&
                  (sq_row(to_sq) == row) &&
                  (sq_col(to_sq) == 3'd6 || sq_col(to_sq) == 3'd2);

      if (sq_col(to_sq) == 3'd6) begin
         rook_dst = make_sq(3'd5, row);
         rook_src = make_sq(3'd7, row);
      end else begin
         rook_dst = make_sq(3'd3, row);
         rook_src = make_sq(3'd0, row);
      end
   end

endmodule

// File: rtl/move_commit.sv
// Move write sequencer: latches an accepted move and issues one registered board
// write per cycle (destination, source, then rook writes for a castle).
module move_commit
   import chess_pkg::*;
#(
   parameter logic [2:0] PROMOTE_TYPE = 3'b010
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [2:0]   currentState,
   input  logic [255:0] board,
   input  logic         moveValid,
   output logic         moveReady,
   input  logic [5:0]   moveFrom,
   input  logic [5:0]   moveTo,
   output logic [10:0]  changePiece,
   output logic         moveDone,
   output logic         moveError,
   output logic [3:0]   captured
);

   commit_state_e state_q, state_d;
   logic [5:0]  from_q, from_d, to_q, to_d;
   logic [3:0]  src_q, src_d, dst_q, dst_d;
   logic [10:0] change_piece_q, change_piece_d;
   logic        move_done_q, move_done_d;
   logic        move_error_q, move_error_d;
   logic [3:0]  captured_q, captured_d;

   logic        game_init, accept;
   logic [3:0]  new_piece, rook_piece;
   logic        is_castle;
   logic [5:0]  rook_dst, rook_src;

   move_classify #(.PROMOTE_TYPE(PROMOTE_TYPE)) u_classify (
      .from_sq    (from_d),
      .to_sq      (to_d),
      .src_piece  (src_d),
      .new_piece  (new_piece),
      .is_castle  (is_castle),
      .rook_piece (rook_piece),
      .rook_dst   (rook_dst),
      .rook_src   (rook_src)
   );

   assign game_init = (currentState == GAME_INIT);
   assign moveReady = (state_q == IDLE) && !game_init;
   assign accept    = moveValid && moveReady;

   always_comb begin
      state_d      = state_q;
      from_d       = from_q;
      to_d         = to_q;
      src_d        = src_q;
      dst_d        = dst_q;
      move_error_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               from_d = moveFrom;
               to_d   = moveTo;
               src_d  = board[{moveFrom, 2'b00} +: 4];
               dst_d  = board[{moveTo, 2'b00} +: 4];
               if (src_d[2:0] == EMPTY || moveFrom == moveTo)
                  move_error_d = 1'b1;
               else
                  state_d = WDST;
            end
         end
         WDST:    state_d = WSRC;
         WSRC:    state_d = is_castle ? RDST : DONE;
         RDST:    state_d = RSRC;
         RSRC:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Re-initialising the board abandons any move in flight.
      if (state_q != IDLE && game_init)
         state_d = IDLE;

      // Outputs are registered, so they are decoded from the state being entered.
      change_piece_d = 11'h000;
      case (state_d)
         WDST:    change_piece_d = {1'b1, new_piece, to_d};
         WSRC:    change_piece_d = {1'b1, 4'b0000, from_d};
         RDST:    change_piece_d = {1'b1, rook_piece, rook_dst};
         RSRC:    change_piece_d = {1'b1, 4'b0000, rook_src};
         default: change_piece_d = 11'h000;
      endcase

      move_done_d = (state_d == DONE);
      captured_d  = move_done_d ? dst_d : 4'h0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         from_q         <= '0;
         to_q           <= '0;
         src_q          <= '0;
         dst_q          <= '0;
         change_piece_q <= '0;
         move_done_q    <= 1'b0;
         move_error_q   <= 1'b0;
         captured_q     <= '0;
      end else begin
         state_q        <= state_d;
         from_q         <= from_d;
         to_q           <= to_d;
         src_q          <= src_d;
         dst_q          <= dst_d;
         change_piece_q <= change_piece_d;
         move_done_q    <= move_done_d;
         move_error_q   <= move_error_d;
         captured_q     <= captured_d;
      end
   end

   assign changePiece = change_piece_q;
   assign moveDone    = move_done_q;
   assign moveError   = move_error_q;
   assign captured    = captured_q;

endmodule
